// File: rtl/fault_inj_pkg.sv
// Shared types and helpers for the fault campaign injector.
// Holds mode/state enums, LFSR constants and the burst mask builder.
package fault_inj_pkg;

    typedef enum logic [1:0] {
        SWEEP  = 2'd0,
        SINGLE = 2'd1,
        RANDOM = 2'd2,
        RSVD   = 2'd3
    } fi_mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_PULSE = 2'd2,
        S_DONE  = 2'd3
    } fi_state_e;

    // 16-bit Fibonacci LFSR, taps 16/14/13/11 seen from the shift-out end
    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam int MAX_N     = 4096;
    localparam int MAX_BURST = 8;

    // Mask with bits addr..addr+burst-1 set, wrapping modulo n
    function automatic logic [MAX_N-1:0] burst_mask(
        input logic [11:0]  addr,
        input logic [3:0]   burst,
        input int unsigned  n
    );
        logic [MAX_N-1:0] m;
        logic [12:0]      idx;
        m = '0;
        for (int unsigned k = 0; k < MAX_BURST; k++) begin
            if (k < 32'(burst)) begin
                idx = {1'b0, addr} + 13'(k);
                if (idx >= 13'(n)) idx = idx - 13'(n);
                m[idx[11:0]] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/fi_lfsr.sv
// Random-mode address source for the fault injector.
// 16-bit LFSR, reseeded only by reset, stepped on request.
module fi_lfsr
    import fault_inj_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_i,
    output logic [OUT_W-1:0] rnd_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic              fb;

    assign fb    = ^(lfsr_q & LFSR_TAPS);
    assign rnd_o = lfsr_q[OUT_W-1:0];

    // Shift right, feedback enters at the top bit
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else if (adv_i) begin
            lfsr_q <= {fb, lfsr_q[LFSR_W-1:1]};
        end
    end

endmodule

// File: rtl/fault_campaign_injector.sv
// Runtime-configurable fault campaign injector.
// Sweep, single-target and random campaigns with burst masks.
module fault_campaign_injector
    import fault_inj_pkg::*;
#(
    parameter int          N         = 256,
    parameter int          ADDR_W    = $clog2(N),
    parameter int          CNT_W     = 32,
    parameter int          BURST_MAX = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic [CNT_W-1:0]  delay_i,
    input  logic [CNT_W-1:0]  pulse_len_i,
    input  logic [3:0]        burst_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic              abort_i,
    output logic [N-1:0]      FI_out,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] cur_addr_o,
    output logic [CNT_W-1:0]  inj_count_o
);

    fi_state_e         state_q, state_d;
    fi_mode_e          mode_r;
    logic [CNT_W-1:0]  delay_r, pulse_r, count_r;
    logic [3:0]        burst_r;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  inj_q, inj_inc;
    logic [ADDR_W-1:0] addr_q, next_addr, rand_addr;
    logic [ADDR_W-1:0] rnd;
    logic [N-1:0]      fi_q;
    logic              err_q;

    logic              accept, reject, lfsr_adv, pulse_end;
    logic [3:0]        burst_cl;
    logic [CNT_W-1:0]  pulse_cl;

    fi_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (ADDR_W)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .adv_i (lfsr_adv),
        .rnd_o (rnd)
    );

    assign rand_addr = (32'(rnd) >= 32'(N))
                     ? ADDR_W'(32'(rnd) - 32'(N)) : rnd;

    assign burst_cl = (burst_i == 4'd0) ? 4'd1
                    : (32'(burst_i) > BURST_MAX) ? 4'(BURST_MAX)
                    : burst_i;

    assign pulse_cl = (pulse_len_i == '0) ? CNT_W'(1) : pulse_len_i;

    assign inj_inc = (&inj_q) ? inj_q : inj_q + 1'b1;

    // Address of the injection that follows the current one
    always_comb begin
        next_addr = addr_q;
        unique case (mode_r)
            SWEEP:   next_addr = (addr_q == ADDR_W'(N - 1)) ? '0 : addr_q + 1'b1;
            RANDOM:  next_addr = rand_addr;
            default: next_addr = addr_q;
        endcase
    end

    // Next-state and control decode; abort overrides everything
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        reject    = 1'b0;
        lfsr_adv  = 1'b0;
        pulse_end = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (mode_i == RSVD) begin
                        reject = 1'b1;
                    end else begin
                        accept   = 1'b1;
                        state_d  = S_DELAY;
                        lfsr_adv = (mode_i == RANDOM);
                    end
                end
            end
            S_DELAY: begin
                if (cnt_q >= delay_r) state_d = S_PULSE;
            end
            S_PULSE: begin
                if (cnt_q >= pulse_r) begin
                    pulse_end = 1'b1;
                    if (count_r != '0 && inj_inc == count_r) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_DELAY;
                        lfsr_adv = (mode_r == RANDOM);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort_i && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            lfsr_adv  = 1'b0;
            pulse_end = 1'b0;
        end
    end

    // State, config latch, counters and registered fault mask
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_r  <= SWEEP;
            delay_r <= '0;
            pulse_r <= '0;
            count_r <= '0;
            burst_r <= '0;
            cnt_q   <= '0;
            inj_q   <= '0;
            addr_q  <= '0;
            fi_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= reject;
            if (accept) begin
                mode_r  <= fi_mode_e'(mode_i);
                delay_r <= delay_i;
                pulse_r <= pulse_cl;
                count_r <= count_i;
                burst_r <= burst_cl;
                cnt_q   <= '0;
                inj_q   <= '0;
                addr_q  <= (mode_i == RANDOM) ? rand_addr : target_i;
            end
            if (state_q == S_DELAY) begin
                if (state_d == S_PULSE) begin
                    fi_q  <= N'(burst_mask(12'(addr_q), burst_r, N));
                    cnt_q <= CNT_W'(1);
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (state_q == S_PULSE) begin
                if (pulse_end) begin
                    fi_q  <= '0;
                    inj_q <= inj_inc;
                    cnt_q <= CNT_W'(1);
                    if (state_d == S_DELAY) addr_q <= next_addr;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (state_d == S_IDLE) fi_q <= '0;
        end
    end

    assign FI_out      = fi_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = err_q;
    assign cur_addr_o  = addr_q;
    assign inj_count_o = inj_q;

endmodule

// File: tb/tb_fault_campaign_injector.sv
// Self-checking bench for fault_campaign_injector.
// Directed table, hand sequences and random campaigns vs a trace model.
module tb_fault_campaign_injector;

    localparam int NN = 256;
    localparam int AW = 8;
    localparam int CW = 32;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [1:0]    mode_i;
    logic [AW-1:0] target_i;
    logic [CW-1:0] delay_i, pulse_len_i, count_i;
    logic [3:0]    burst_i;
    logic          abort_i;
    logic [NN-1:0] FI_out;
    logic          busy_o, done_o, err_o;
    logic [AW-1:0] cur_addr_o;
    logic [CW-1:0] inj_count_o;

    int checks   = 0;
    int failures = 0;
    logic [15:0] mdl_lfsr;

    fault_campaign_injector dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .target_i    (target_i),
        .delay_i     (delay_i),
        .pulse_len_i (pulse_len_i),
        .burst_i     (burst_i),
        .count_i     (count_i),
        .abort_i     (abort_i),
        .FI_out      (FI_out),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .cur_addr_o  (cur_addr_o),
        .inj_count_o (inj_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NN-1:0] fi;
        bit            busy;
        bit            done;
        int            inj;
        int            addr;
    } step_t;

    typedef struct {
        logic [1:0] m;
        int         tg;
        int         dl;
        int         pl;
        logic [3:0] bu;
        int         ct;
        int         rise;
        int         high;
        int         inj;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string nm, input logic [NN-1:0] act,
                         input logic [NN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic b;
        b = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {b, s[15:1]};
    endfunction

    function automatic int lfsr_addr(input logic [15:0] s);
        int v;
        v = int'(s) % (1 << AW);
        if (v >= NN) v = v - NN;
        return v;
    endfunction

    function automatic logic [NN-1:0] exp_mask(input int a, input int b);
        logic [NN-1:0] r;
        r = '0;
        for (int k = 0; k < b; k++) r[(a + k) % NN] = 1'b1;
        return r;
    endfunction

    task automatic idle_inputs();
        start_i     = 1'b0;
        mode_i      = 2'd0;
        target_i    = '0;
        delay_i     = '0;
        pulse_len_i = '0;
        burst_i     = '0;
        count_i     = '0;
        abort_i     = 1'b0;
    endtask

    task automatic wait_fi(input bit want, input string nm);
        int n;
        n = 0;
        while (((FI_out != '0) != want) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 60) begin
            failures++;
            $display("FAIL %s timeout act=%0h exp=%0d", nm, FI_out, want);
        end
    endtask

    task automatic run_campaign(
        input  logic [1:0] m,
        input  int         tg,
        input  int         dl,
        input  int         pl,
        input  logic [3:0] bu,
        input  int         ct,
        output int         rise,
        output int         high,
        output int         inj_end
    );
        step_t tr[$];
        step_t e;
        int a, last_a, be, p, z;
        be = (bu == 0) ? 1 : ((bu > 4) ? 4 : int'(bu));
        p  = (pl == 0) ? 1 : pl;
        last_a = tg;
        for (int j = 0; j < ct; j++) begin
            if (m == 2'd0) a = (tg + j) % NN;
            else if (m == 2'd1) a = tg;
            else begin
                a = lfsr_addr(mdl_lfsr);
                mdl_lfsr = lfsr_step(mdl_lfsr);
            end
            z = (j == 0) ? dl + 1 : ((dl == 0) ? 1 : dl);
            for (int i = 0; i < z; i++) tr.push_back('{'0, 1, 0, j, a});
            for (int i = 0; i < p; i++)
                tr.push_back('{exp_mask(a, be), 1, 0, j, a});
            last_a = a;
        end
        tr.push_back('{'0, 1, 1, ct, last_a});
        tr.push_back('{'0, 0, 0, ct, last_a});

        @(negedge clk);
        start_i = 1'b1; mode_i = m; target_i = AW'(tg);
        delay_i = dl; pulse_len_i = pl; burst_i = bu; count_i = ct;
        @(negedge clk);
        rise = -1; high = 0; inj_end = 0;
        for (int i = 0; i < tr.size(); i++) begin
            e = tr[i];
            check($sformatf("fi[%0d]", i), FI_out, e.fi);
            check($sformatf("busy[%0d]", i), NN'(busy_o), NN'(e.busy));
            check($sformatf("done[%0d]", i), NN'(done_o), NN'(e.done));
            check($sformatf("err[%0d]", i), NN'(err_o), '0);
            check($sformatf("inj[%0d]", i), NN'(inj_count_o), NN'(e.inj));
            check($sformatf("addr[%0d]", i), NN'(cur_addr_o), NN'(e.addr));
            if (FI_out != '0) begin
                high++;
                if (rise < 0) rise = i;
            end
            inj_end = int'(inj_count_o);
            if (i < tr.size() - 1) begin
                start_i     = 1'($urandom_range(0, 1));
                mode_i      = 2'($urandom_range(0, 3));
                target_i    = AW'($urandom);
                delay_i     = $urandom_range(0, 9);
                pulse_len_i = $urandom_range(0, 9);
                burst_i     = 4'($urandom);
                count_i     = $urandom_range(0, 9);
            end else begin
                idle_inputs();
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int rise, high, ie;
        logic [NN-1:0] em;

        tbl[0] = '{2'd0, 254, 3, 2, 4'd1, 4, 4, 8, 4};
        tbl[1] = '{2'd1, 255, 0, 0, 4'd3, 1, 1, 1, 1};
        tbl[2] = '{2'd2,   0, 1, 1, 4'd1, 5, 2, 5, 5};
        tbl[3] = '{2'd2,  77, 2, 1, 4'd2, 5, 3, 5, 5};
        tbl[4] = '{2'd1, 254, 1, 3, 4'd9, 1, 2, 3, 1};
        tbl[5] = '{2'd0, 255, 0, 1, 4'd0, 3, 1, 3, 3};

        idle_inputs();
        rst = 1'b1;
        mdl_lfsr = SEED;
        repeat (3) @(negedge clk);
        check("rst_fi", FI_out, '0);
        check("rst_busy", NN'(busy_o), '0);
        check("rst_done", NN'(done_o), '0);
        check("rst_err", NN'(err_o), '0);
        check("rst_addr", NN'(cur_addr_o), '0);
        check("rst_inj", NN'(inj_count_o), '0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_campaign(tbl[v].m, tbl[v].tg, tbl[v].dl, tbl[v].pl,
                         tbl[v].bu, tbl[v].ct, rise, high, ie);
            check($sformatf("tbl%0d_rise", v), NN'(rise), NN'(tbl[v].rise));
            check($sformatf("tbl%0d_high", v), NN'(high), NN'(tbl[v].high));
            check($sformatf("tbl%0d_inj", v), NN'(ie), NN'(tbl[v].inj));
        end

        em = '0;
        em[255] = 1'b1; em[0] = 1'b1; em[1] = 1'b1;
        @(negedge clk);
        start_i = 1'b1; mode_i = 2'd1; target_i = 8'd255;
        delay_i = 0; pulse_len_i = 0; burst_i = 4'd3; count_i = 1;
        @(negedge clk);
        idle_inputs();
        check("single_d0", FI_out, '0);
        @(negedge clk);
        check("single_mask", FI_out, em);
        check("single_nodone", NN'(done_o), '0);
        @(negedge clk);
        check("single_off", FI_out, '0);
        check("single_done", NN'(done_o), NN'(1));
        @(negedge clk);
        check("single_idle", NN'(busy_o), '0);

        start_i = 1'b1; mode_i = 2'd3;
        @(negedge clk);
        start_i = 1'b0;
        check("rsvd_err", NN'(err_o), NN'(1));
        check("rsvd_busy", NN'(busy_o), '0);
        @(negedge clk);
        check("rsvd_err_clr", NN'(err_o), '0);
        check("rsvd_busy2", NN'(busy_o), '0);

        start_i = 1'b1; mode_i = 2'd0; target_i = 8'd10;
        delay_i = 1; pulse_len_i = 3; burst_i = 4'd2; count_i = 0;
        @(negedge clk);
        idle_inputs();
        wait_fi(1'b1, "abort_rise1");
        wait_fi(1'b0, "abort_fall1");
        wait_fi(1'b1, "abort_rise2");
        check("abort_mask", FI_out, exp_mask(11, 2));
        check("abort_inj_pre", NN'(inj_count_o), NN'(1));
        @(negedge clk);
        check("abort_mask2", FI_out, exp_mask(11, 2));
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_fi", FI_out, '0);
        check("abort_busy", NN'(busy_o), '0);
        check("abort_done", NN'(done_o), '0);
        check("abort_inj", NN'(inj_count_o), NN'(1));
        @(negedge clk);
        check("abort_done2", NN'(done_o), '0);
        check("abort_inj2", NN'(inj_count_o), NN'(1));

        for (int r = 0; r < 25; r++) begin
            int ct;
            ct = $urandom_range(1, 4);
            run_campaign(2'($urandom_range(0, 2)), $urandom_range(0, NN - 1),
                         $urandom_range(0, 4), $urandom_range(0, 3),
                         4'($urandom), ct, rise, high, ie);
            check($sformatf("rnd%0d_inj", r), NN'(ie), NN'(ct));
        end

        @(negedge clk);
        start_i = 1'b1; mode_i = 2'd1; target_i = 8'd5;
        delay_i = 0; pulse_len_i = 4; burst_i = 4'd1; count_i = 2;
        @(negedge clk);
        idle_inputs();
        wait_fi(1'b1, "rst_pulse_rise");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_lfsr = SEED;
        check("rstp_fi", FI_out, '0);
        check("rstp_busy", NN'(busy_o), '0);
        check("rstp_done", NN'(done_o), '0);
        check("rstp_addr", NN'(cur_addr_o), '0);
        check("rstp_inj", NN'(inj_count_o), '0);

        run_campaign(2'd2, 0, 0, 1, 4'd1, 3, rise, high, ie);
        check("reseed_inj", NN'(ie), NN'(3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fault_campaign_injector.md
Name: fault_campaign_injector

Overview:
- Runtime-configurable successor to the fixed-delay, fixed-pulse fault injector.
- Drives an N-bit one-hot or burst fault mask into the target fault-injection points.
- Supports three campaign modes: sequential sweep, single-target repeat, and pseudorandom target selection.
- Supports multi-bit adjacent bursts, per-campaign delay, pulse length, injection count, abort, and status outputs for a campaign controller or testbench sequencer.

Parameters:
- N, 256: number of fault-injection outputs (2..4096).
- ADDR_W, $clog2(N): target address width.
- CNT_W, 32: width of the delay, pulse and count fields.
- BURST_MAX, 4: maximum adjacent bits faulted per injection (1..8).
- LFSR_SEED, 16'hACE1: reset seed of the random-mode LFSR; must be nonzero.

Ports:
- clk, in, 1: single clock; all logic is rising-edge.
- rst, in, 1: reset, synchronous, active-high.
- start_i, in, 1: starts a campaign; sampled only in IDLE.
- mode_i, in, 2: campaign mode. 0 = SWEEP, 1 = SINGLE, 2 = RANDOM, 3 = reserved.
- target_i, in, ADDR_W: start address (SWEEP) or fixed address (SINGLE); ignored in RANDOM.
- delay_i, in, CNT_W: idle cycles before each pulse.
- pulse_len_i, in, CNT_W: cycles each pulse is held.
- burst_i, in, 4: bits per injection.
- count_i, in, CNT_W: injections per campaign; 0 = continuous.
- abort_i, in, 1: terminates the campaign.
- FI_out, out, N: fault mask, registered.
- busy_o, out, 1: high in any non-IDLE state.
- done_o, out, 1: one-cycle pulse on normal completion.
- err_o, out, 1: one-cycle pulse when a start request is rejected.
- cur_addr_o, out, ADDR_W: base address of the current or next injection.
- inj_count_o, out, CNT_W: completed injections; saturates at all-ones.

Behaviour:
- Reset (rst=1 at a rising edge):
  - All outputs are 0 and the state is IDLE.
  - The LFSR is loaded with LFSR_SEED.
  - This holds from any state, including mid-pulse: FI_out is 0 after that edge.
- States: IDLE, DELAY, PULSE, DONE.
- IDLE:
  - start_i=1 with mode_i in {0,1,2}: latch all config inputs; inj_count_o := 0; go to DELAY.
  - Loaded cur_addr is target_i for SWEEP and SINGLE. For RANDOM it is the LFSR-derived address, and the LFSR then advances.
  - start_i=1 with mode_i=3: err_o pulses for one cycle; the block stays in IDLE.
- Config clamping at latch:
  - pulse_len = 0 is treated as 1.
  - burst = 0 is treated as 1; burst > BURST_MAX is clamped to BURST_MAX.
- DELAY:
  - Counts delay cycles, then moves to PULSE.
  - delay = 0 means PULSE is entered on the very next edge.
- Timing: with start sampled at edge t, FI_out first goes high at edge t+1+delay and stays high exactly pulse_len cycles.
- PULSE:
  - FI_out bit (cur_addr+k) mod N is 1 for k = 0..burst-1; all other bits are 0.
  - On the last pulse cycle, inj_count_o increments.
  - If count ≠ 0 and the new count equals count, go to DONE. Otherwise advance the address and go to DELAY.
  - FI_out returns to 0 on the edge that leaves PULSE.
- Address advance:
  - SWEEP: cur_addr+1, wrapping N-1 → 0.
  - SINGLE: unchanged.
  - RANDOM: take lfsr[ADDR_W-1:0]; if the value is ≥ N, subtract N. The LFSR advances once per injection.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11. State persists across campaigns; only rst reseeds it.
- DONE: done_o=1 for one cycle, then IDLE. busy_o is high in DONE.
- abort_i (any non-IDLE state, including DONE):
  - On the next edge FI_out=0 and state=IDLE; done_o is not asserted.
  - inj_count_o holds its value.
  - abort_i has priority over every other transition.
- start_i while busy is ignored, with no error pulse.
- Config input changes mid-campaign have no effect.
- Simultaneous rst and any other input: rst wins.
- Counters are compared with full CNT_W width; there is no wrap inside DELAY or PULSE.

Decomposition:
- Package fault_inj_pkg:
  - fi_mode_e enum (SWEEP, SINGLE, RANDOM, RSVD).
  - fi_state_e enum.
  - LFSR width/taps constants.
  - Function burst_mask(addr, burst) returning the wrapped N-bit mask.
- One sub-module, fi_lfsr: 16-bit LFSR with sync reset to seed and an advance enable.
- The FSM, counters and mask register stay in fault_campaign_injector.

Test Plan:
- SWEEP, target=254, delay=3, pulse=2, burst=1, count=4, N=256:
  - Pulses at bits 254, 255, 0, 1; each high exactly 2 cycles.
  - First rise 4 cycles after start; 3 zero cycles between pulses.
  - done_o pulses once; inj_count_o=4.
- SINGLE, target=255, burst=3, delay=0, pulse=0, count=1:
  - FI_out = bits {255, 0, 1} for exactly 1 cycle, 1 cycle after start.
  - done_o follows.
- RANDOM, count=5:
  - Addresses match the reference model LFSR from 16'hACE1 with the reduction rule.
  - A second campaign continues the sequence without reseeding.
- Abort:
  - abort_i asserted on the 2nd cycle of a pulse in a continuous campaign (count=0).
  - FI_out=0 and busy_o=0 next cycle; no done_o; inj_count_o unchanged.
- rst asserted during PULSE → all outputs 0 the next cycle.
- mode_i=3 at start → err_o 1 cycle, busy_o stays 0.
- start_i while busy → ignored, campaign unaffected.
